// File: rtl/dmux_pkg.sv
// Shared widths, slot type and helpers for the serial-to-parallel demux collector.
package dmux_pkg;
   localparam int SEL_W  = 2;
   localparam int WORD_W = 4;

   typedef logic [SEL_W-1:0]  slot_t;
   typedef logic [WORD_W-1:0] word_t;

   localparam slot_t LAST_SLOT = 2'd3;

   // Slot counter step; natural 2-bit wrap takes 3 back to 0.
   function automatic slot_t slot_inc(input slot_t s);
      return s + 1'b1;
   endfunction
endpackage

// File: rtl/dmux_word_fifo.sv
// Small output FIFO of assembled words; head entry is always visible on o_head.
module dmux_word_fifo
   import dmux_pkg::*;
#(
   parameter int OUT_DEPTH = 2,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  word_t            push_word,
   input  logic             pop,
   output word_t            head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

   word_t            r_mem [OUT_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_push;
   logic             w_pop;

   assign full  = (r_cnt == CNT_W'(OUT_DEPTH));
   assign empty = (r_cnt == '0);
   assign count = r_cnt;
   assign head  = r_mem[r_rd_ptr];

   // A push into a full FIFO is only taken when the head leaves on the same edge.
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         for (int k = 0; k < OUT_DEPTH; k++) r_mem[k] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= push_word;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push & ~w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (~w_push & w_pop) r_cnt <= r_cnt - 1'b1;
      end
   end
endmodule

// File: rtl/dmux_sp_collect.sv
// Serial-to-parallel collector: steers bits through an external 1x4 demux,
// assembles 4-bit words and queues them in an output FIFO.
module dmux_sp_collect
   import dmux_pkg::*;
#(
   parameter int OUT_DEPTH = 2,
   parameter int CNT_W     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic              bit_ready,
   input  logic              flush,
   output logic              dmux_i,
   output logic [SEL_W-1:0]  dmux_sel,
   input  logic [WORD_W-1:0] dmux_out,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              partial
);
   slot_t            r_slot;
   word_t            r_asm;
   logic             w_acc;
   logic             w_complete;
   logic             w_flush_go;
   logic             w_push;
   slot_t            w_slot_acc;
   word_t            w_asm_acc;
   word_t            w_head;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_cnt;

   // Only slot 3 can complete a word, so only it must wait for FIFO space.
   assign bit_ready = (r_slot != LAST_SLOT) | ~w_full;
   assign w_acc     = bit_valid & bit_ready;

   assign dmux_i   = bit_in & w_acc;
   assign dmux_sel = r_slot;

   assign w_asm_acc  = r_asm | (w_acc ? dmux_out : '0);
   assign w_slot_acc = w_acc ? slot_inc(r_slot) : r_slot;
   assign w_complete = w_acc & (r_slot == LAST_SLOT);

   // Flush sees the state after any bit accepted this cycle; a completing bit
   // already pushes, so flush adds nothing then.
   assign w_flush_go = flush & ~w_complete & (w_slot_acc != '0)
                     & (w_cnt < CNT_W'(OUT_DEPTH));
   assign w_push     = w_complete | w_flush_go;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot <= '0;
         r_asm  <= '0;
      end else if (w_push) begin
         r_slot <= '0;
         r_asm  <= '0;
      end else begin
         r_slot <= w_slot_acc;
         r_asm  <= w_asm_acc;
      end
   end

   dmux_word_fifo #(
      .OUT_DEPTH (OUT_DEPTH),
      .CNT_W     (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_word (w_asm_acc),
      .pop       (word_ready),
      .head      (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .count     (w_cnt)
   );

   assign word_out   = w_head;
   assign word_valid = ~w_empty;
   assign partial    = (r_slot != '0);
endmodule
